// File: rtl/ins_tilt_seq.sv
`timescale 1ns/1ps
// Tilt sequencer: issues roll then pitch atan2 requests for one accelerometer
// sample, returns both angles with a pulse, and guards each request with a watchdog.
module ins_tilt_seq #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      ax,
    input  logic [31:0]      ay,
    input  logic [31:0]      az,
    output logic             in_ready,
    output logic             atan_en,
    output logic [31:0]      atan_a,
    output logic [31:0]      atan_b,
    input  logic [31:0]      atan_result,
    input  logic             atan_finish,
    output logic [31:0]      roll,
    output logic [31:0]      pitch,
    output logic             out_valid,
    output logic             err,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, ROLL_REQ, ROLL_WAIT, PITCH_GAP, PITCH_REQ, PITCH_WAIT, DONE
    } state_t;

    state_t          state, state_nxt;
    logic [31:0]     ax_l, ay_l, az_l;
    logic [WD_W-1:0] wd;
    logic            err_l;
    logic            accept, drop, in_wait, timeout_hit;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign atan_en   = (state == ROLL_REQ) || (state == PITCH_REQ);
    assign out_valid = (state == DONE);
    assign err       = out_valid & err_l;
    assign accept    = in_valid & in_ready;
    assign drop      = in_valid & ~in_ready;
    assign in_wait   = (state == ROLL_WAIT) || (state == PITCH_WAIT);
    // A finish arriving on the last watchdog cycle still wins over the timeout.
    assign timeout_hit = in_wait && !atan_finish && (wd == WD_LAST);

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        atan_a    = '0;
        atan_b    = '0;
        unique case (state)
            IDLE: begin
                if (in_valid) state_nxt = ROLL_REQ;
            end
            ROLL_REQ: begin
                atan_a    = az_l;
                atan_b    = ay_l;
                state_nxt = ROLL_WAIT;
            end
            ROLL_WAIT: begin
                atan_a = az_l;
                atan_b = ay_l;
                if (atan_finish)      state_nxt = PITCH_GAP;
                else if (timeout_hit) state_nxt = DONE;
            end
            PITCH_GAP: begin
                state_nxt = PITCH_REQ;
            end
            PITCH_REQ: begin
                atan_a    = az_l;
                atan_b    = {~ax_l[31], ax_l[30:0]};
                state_nxt = PITCH_WAIT;
            end
            PITCH_WAIT: begin
                atan_a = az_l;
                atan_b = {~ax_l[31], ax_l[30:0]};
                if (atan_finish || timeout_hit) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ax_l     <= '0;
            ay_l     <= '0;
            az_l     <= '0;
            wd       <= '0;
            err_l    <= 1'b0;
            roll     <= '0;
            pitch    <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ax_l <= ax;
                ay_l <= ay;
                az_l <= az;
            end
            if (atan_en)      wd <= '0;
            else if (in_wait) wd <= wd + 1'b1;
            if (state == ROLL_WAIT && atan_finish)  roll  <= atan_result;
            if (state == PITCH_WAIT && atan_finish) pitch <= atan_result;
            if (timeout_hit)        err_l <= 1'b1;
            else if (state == DONE) err_l <= 1'b0;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ins_tilt_seq.sv
`timescale 1ns/1ps
// Bench for ins_tilt_seq: a default instance served by a queued atan model and
// scoreboard, plus a TIMEOUT=16 / CNT_W=4 instance driven by hand for the corners.
module tb_ins_tilt_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, atan_en, atan_finish, out_valid, err, busy;
    logic [31:0] ax, ay, az, atan_a, atan_b, atan_result, roll, pitch;
    logic [7:0]  drop_cnt;

    logic        s_rst, s_in_valid, s_in_ready, s_atan_en, s_atan_finish, s_out_valid, s_err, s_busy;
    logic [31:0] s_ax, s_ay, s_az, s_atan_a, s_atan_b, s_atan_result, s_roll, s_pitch;
    logic [3:0]  s_drop_cnt;

    ins_tilt_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ax(ax), .ay(ay), .az(az),
        .in_ready(in_ready), .atan_en(atan_en), .atan_a(atan_a), .atan_b(atan_b),
        .atan_result(atan_result), .atan_finish(atan_finish), .roll(roll), .pitch(pitch),
        .out_valid(out_valid), .err(err), .busy(busy), .drop_cnt(drop_cnt)
    );

    ins_tilt_seq #(.TIMEOUT(16), .CNT_W(4)) dut_s (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .ax(s_ax), .ay(s_ay), .az(s_az),
        .in_ready(s_in_ready), .atan_en(s_atan_en), .atan_a(s_atan_a), .atan_b(s_atan_b),
        .atan_result(s_atan_result), .atan_finish(s_atan_finish), .roll(s_roll), .pitch(s_pitch),
        .out_valid(s_out_valid), .err(s_err), .busy(s_busy), .drop_cnt(s_drop_cnt)
    );

    typedef struct {logic [31:0] a, b, res; int lat; bit stale;} req_t;
    typedef struct {logic [31:0] roll, pitch; logic err; int due;} out_t;
    typedef struct {
        logic [31:0] ax, ay, az, rr, rp, exp_b2;
        int          lr, lp, exp_lat;
        bit          st_r, st_p;
    } vec_t;

    req_t        req_q[$];
    out_t        out_q[$];
    out_t        mon_o;
    int          n_vec = 0, n_bad = 0, n_done = 0, cyc = 0;
    int          pend = 0;
    bit          hold_chk = 1'b0;
    logic [31:0] cap_a, cap_b, pend_res;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sample(input vec_t v, input int due);
        req_q.push_back('{a: v.az, b: v.ay, res: v.rr, lat: v.lr, stale: v.st_r});
        req_q.push_back('{a: v.az, b: v.exp_b2, res: v.rp, lat: v.lp, stale: v.st_p});
        out_q.push_back('{roll: v.rr, pitch: v.rp, err: 1'b0, due: due});
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            tick();
            k++;
        end
        check("done_in_time", 32'(n_done >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input logic [7:0] exp_drop);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_atan_en", atan_en, 0);
        check("rst_atan_a", atan_a, 0);
        check("rst_atan_b", atan_b, 0);
        check("rst_roll", roll, 0);
        check("rst_pitch", pitch, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_err", err, 0);
        check("rst_drop_cnt", drop_cnt, exp_drop);
    endtask

    // atan model: answers each request after its queued latency, optionally with a stale pulse in the en cycle
    initial begin
        req_t r;
        atan_finish = 1'b0;
        atan_result = '0;
        forever begin
            tick();
            atan_finish = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    atan_finish = 1'b1;
                    atan_result = pend_res;
                    hold_chk    = 1'b0;
                end
            end
            if (atan_en) begin
                if (req_q.size() == 0) begin
                    check("unexpected_atan_en", 32'd1, 32'd0);
                end else begin
                    r = req_q.pop_front();
                    check("req_atan_a", atan_a, r.a);
                    check("req_atan_b", atan_b, r.b);
                    cap_a    = r.a;
                    cap_b    = r.b;
                    hold_chk = 1'b1;
                    pend     = r.lat;
                    pend_res = r.res;
                    if (r.stale) begin
                        atan_finish = 1'b1;
                        atan_result = 32'hDEADBEEF;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (hold_chk) begin
            check("hold_atan_a", atan_a, cap_a);
            check("hold_atan_b", atan_b, cap_b);
        end
        if (out_valid) begin
            if (out_q.size() == 0) begin
                check("spurious_out_valid", out_valid, 0);
            end else begin
                mon_o = out_q.pop_front();
                check("out_roll", roll, mon_o.roll);
                check("out_pitch", pitch, mon_o.pitch);
                check("out_err", err, mon_o.err);
                check("out_cycle", cyc, mon_o.due);
            end
            n_done++;
        end
    end

    initial begin
        vec_t vecs[4];
        vec_t rv;
        int   t0, tgt;
        vecs[0] = '{ax: 32'h00000000, ay: 32'h3F800000, az: 32'h3F800000, rr: 32'h3F490FDB,
                    rp: 32'h00000000, exp_b2: 32'h80000000, lr: 28, lp: 28, exp_lat: 60, st_r: 0, st_p: 0};
        vecs[1] = '{ax: 32'hBF000000, ay: 32'h3E800000, az: 32'h3F800000, rr: 32'h3E7ADBB0,
                    rp: 32'h3EED6338, exp_b2: 32'h3F000000, lr: 5, lp: 7, exp_lat: 16, st_r: 0, st_p: 0};
        vecs[2] = '{ax: 32'h40000000, ay: 32'hC0400000, az: 32'hBF800000, rr: 32'hBF9A2B5C,
                    rp: 32'hC0000000, exp_b2: 32'hC0000000, lr: 10, lp: 3, exp_lat: 17, st_r: 1, st_p: 1};
        vecs[3] = '{ax: 32'h80000000, ay: 32'h7F800000, az: 32'h00000001, rr: 32'h40490FDB,
                    rp: 32'h3FC90FDB, exp_b2: 32'h00000000, lr: 1, lp: 1, exp_lat: 6, st_r: 0, st_p: 0};

        rst = 1'b1; in_valid = 1'b0; ax = '0; ay = '0; az = '0;
        s_rst = 1'b1; s_in_valid = 1'b0; s_ax = '0; s_ay = '0; s_az = '0;
        s_atan_finish = 1'b0; s_atan_result = '0;
        tick();
        tick();
        rst = 1'b0;
        s_rst = 1'b0;
        @(negedge clk);
        check_reset_outputs(8'd0);
        check("s_rst_in_ready", s_in_ready, 1);
        check("s_rst_drop_cnt", s_drop_cnt, 0);

        foreach (vecs[i]) begin
            tick();
            tgt = n_done + 1;
            ax = vecs[i].ax; ay = vecs[i].ay; az = vecs[i].az;
            in_valid = 1'b1;
            expect_sample(vecs[i], cyc + vecs[i].exp_lat);
            tick();
            in_valid = 1'b0;
            wait_done(tgt, 200);
        end
        check("drop_after_vectors", drop_cnt, 0);

        // Back-pressure: 100 cycles of in_valid accept at t0 and t0+61, drop the other 98
        tick();
        t0  = cyc;
        tgt = n_done + 2;
        ax = vecs[0].ax; ay = vecs[0].ay; az = vecs[0].az;
        in_valid = 1'b1;
        expect_sample(vecs[0], t0 + 60);
        expect_sample(vecs[0], t0 + 121);
        repeat (100) tick();
        in_valid = 1'b0;
        wait_done(tgt, 200);
        check("drop_backpressure", drop_cnt, 98);

        // Reset during PITCH_WAIT; the pitch finish still fires later and must be ignored
        rv = '{ax: 32'h3F800000, ay: 32'h00000000, az: 32'h3F800000, rr: 32'h3E000000,
               rp: 32'h3F000000, exp_b2: 32'hBF800000, lr: 4, lp: 40, exp_lat: 48, st_r: 0, st_p: 0};
        tick();
        ax = rv.ax; ay = rv.ay; az = rv.az;
        in_valid = 1'b1;
        req_q.push_back('{a: rv.az, b: rv.ay, res: rv.rr, lat: rv.lr, stale: 1'b0});
        req_q.push_back('{a: rv.az, b: rv.exp_b2, res: rv.rp, lat: rv.lp, stale: 1'b0});
        tick();
        in_valid = 1'b0;
        repeat (11) tick();
        rst = 1'b1;
        hold_chk = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs(8'd0);
        for (int k = 0; k < 100 && pend > 0; k++) tick();
        tick();
        @(negedge clk);
        check("stray_pitch", pitch, 0);
        check("stray_roll", roll, 0);
        check("stray_busy", busy, 0);

        // Short-timeout instance: one answered sample (Lr=Lp=2)
        tick();
        s_ax = 32'h3F000000; s_ay = 32'h3F800000; s_az = 32'h40000000;
        s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        @(negedge clk);
        check("s_en_roll", s_atan_en, 1);
        check("s_a_roll", s_atan_a, 32'h40000000);
        check("s_b_roll", s_atan_b, 32'h3F800000);
        tick();
        tick();
        s_atan_finish = 1'b1; s_atan_result = 32'h3F111111;
        tick();
        s_atan_finish = 1'b0;
        tick();
        @(negedge clk);
        check("s_en_pitch", s_atan_en, 1);
        check("s_a_pitch", s_atan_a, 32'h40000000);
        check("s_b_pitch", s_atan_b, 32'hBF000000);
        tick();
        tick();
        s_atan_finish = 1'b1; s_atan_result = 32'hBE222222;
        tick();
        s_atan_finish = 1'b0;
        @(negedge clk);
        check("s_ok_out_valid", s_out_valid, 1);
        check("s_ok_err", s_err, 0);
        check("s_ok_roll", s_roll, 32'h3F111111);
        check("s_ok_pitch", s_pitch, 32'hBE222222);

        // Silent roll request: err pulse exactly 1+16+1 cycles after accept, angles held
        tick();
        s_in_valid = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            s_in_valid = 1'b0;
            @(negedge clk);
            check("s_to_out_valid", s_out_valid, 32'(k == 18));
        end
        check("s_to_err", s_err, 1);
        check("s_to_roll", s_roll, 32'h3F111111);
        check("s_to_pitch", s_pitch, 32'hBE222222);
        tick();
        @(negedge clk);
        check("s_to_in_ready", s_in_ready, 1);
        s_atan_finish = 1'b1; s_atan_result = 32'hFFFFFFFF;
        tick();
        s_atan_finish = 1'b0;
        @(negedge clk);
        check("s_stray_busy", s_busy, 0);
        check("s_stray_out_valid", s_out_valid, 0);
        check("s_stray_roll", s_roll, 32'h3F111111);
        check("s_stray_pitch", s_pitch, 32'hBE222222);

        // Saturation of the 4-bit drop counter
        tick();
        s_in_valid = 1'b1;
        repeat (100) tick();
        s_in_valid = 1'b0;
        @(negedge clk);
        check("s_drop_saturated", s_drop_cnt, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
